// File: rtl/fadd_pipe.sv
// Multi-cycle IEEE-754 adder/subtractor: ALIGN -> ADD -> iterative NORM -> ROUND -> HOLD.
// NaN/infinity operands bypass the datapath and are written into the result register on accept.
module fadd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] num1,
    input  logic [EXP_W+MAN_W:0] num2,
    input  logic                 sub,
    input  logic [2:0]           rm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_num,
    output logic [4:0]           flags,
    output logic [2:0]           dbg_state
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int DW = MAN_W + 4;  // hidden + fraction + guard/round/sticky
    localparam int XW = EXP_W + 1;  // one spare bit so overflow is visible
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [XW-1:0]    X_ONE    = XW'(1);
    localparam logic [XW-1:0]    X_TWO    = XW'(2);
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    // Handshake: operands transfer on a rising edge with in_valid && in_ready (IDLE only);
    // the result transfers on a rising edge with out_valid && out_ready (HOLD only).
    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [2:0]       rm_q, rm_d;
    logic             sign_q, sign_d, eff_sub_q, eff_sub_d;
    logic [XW-1:0]    exp_q, exp_d;
    logic [DW-1:0]    mant_l_q, mant_l_d, mant_s_q, mant_s_d;
    logic [DW:0]      sum_q, sum_d;
    logic [W-1:0]     out_num_q, out_num_d;
    logic [4:0]       flags_q, flags_d;

    logic [EXP_W-1:0] e1, e2;
    logic [MAN_W-1:0] f1, f2;
    logic             nan1, nan2, snan_any, inf1, inf2, sb2, special;
    logic [W-1:0]     spec_num;
    logic [4:0]       spec_flags;

    assign e1       = num1[W-2:MAN_W];
    assign e2       = num2[W-2:MAN_W];
    assign f1       = num1[MAN_W-1:0];
    assign f2       = num2[MAN_W-1:0];
    assign nan1     = (e1 == EXP_ONES) && (f1 != '0);
    assign nan2     = (e2 == EXP_ONES) && (f2 != '0);
    assign inf1     = (e1 == EXP_ONES) && (f1 == '0);
    assign inf2     = (e2 == EXP_ONES) && (f2 == '0);
    assign snan_any = (nan1 && !f1[MAN_W-1]) || (nan2 && !f2[MAN_W-1]);
    assign sb2      = num2[W-1] ^ sub;
    assign special  = nan1 || nan2 || inf1 || inf2;

    always_comb begin
        spec_num   = {sb2, EXP_ONES, {MAN_W{1'b0}}};
        spec_flags = '0;
        if (nan1 || nan2) begin
            spec_num   = QNAN;
            spec_flags = {snan_any, 4'b0000};
        end else if (inf1 && inf2 && (num1[W-1] != sb2)) begin
            spec_num   = QNAN;
            spec_flags = 5'b10000;
        end else if (inf1) begin
            spec_num   = {num1[W-1], EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    // Alignment: zero/subnormal operands use effective exponent 1 and hidden bit 0.
    logic [EXP_W-1:0] ea, eb;
    logic             a_big;
    logic [DW-1:0]    ma, mb, ml, ms, ms_sh;
    logic [XW-1:0]    xa, xb, xl, xs;
    logic [31:0]      diff;

    assign ea    = a_q[W-2:MAN_W];
    assign eb    = b_q[W-2:MAN_W];
    assign a_big = a_q[W-2:0] >= b_q[W-2:0];
    assign ma    = {|ea, a_q[MAN_W-1:0], 3'b000};
    assign mb    = {|eb, b_q[MAN_W-1:0], 3'b000};
    assign xa    = (ea == '0) ? X_ONE : {1'b0, ea};
    assign xb    = (eb == '0) ? X_ONE : {1'b0, eb};
    assign xl    = a_big ? xa : xb;
    assign xs    = a_big ? xb : xa;
    assign ml    = a_big ? ma : mb;
    assign ms    = a_big ? mb : ma;
    assign diff  = 32'(xl) - 32'(xs);

    always_comb begin
        if (diff >= 32'(MAN_W + 3)) begin
            ms_sh = {{(DW-1){1'b0}}, |ms};
        end else begin
            ms_sh    = ms >> diff;
            ms_sh[0] = ms_sh[0] | (|(ms & ((DW'(1) << diff) - DW'(1))));
        end
    end

    // Rounding of the normalised sum held in sum_q / exp_q.
    logic [DW-1:0]    m;
    logic             g, r, st, lsb, inexact, tiny, inc, ovf, ovf_to_inf, zsign;
    logic [MAN_W+1:0] rsig;
    logic [MAN_W-1:0] r_frac;
    logic [XW-1:0]    r_exp;
    logic [W-1:0]     rnd_num;
    logic [4:0]       rnd_flags;

    assign m       = sum_q[DW-1:0];
    assign g       = m[2];
    assign r       = m[1];
    assign st      = m[0];
    assign lsb     = m[3];
    assign inexact = g | r | st;
    assign tiny    = (exp_q == X_ONE) && !m[DW-1];
    assign rsig    = {1'b0, m[DW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    assign ovf     = r_exp >= {1'b0, EXP_ONES};
    assign zsign   = eff_sub_q ? (rm_q == 3'b010) : sign_q;

    always_comb begin
        inc        = g & (r | st | lsb);
        ovf_to_inf = 1'b1;
        case (rm_q)
            3'b001: begin inc = 1'b0;               ovf_to_inf = 1'b0;    end
            3'b010: begin inc = sign_q & inexact;   ovf_to_inf = sign_q;  end
            3'b011: begin inc = !sign_q & inexact;  ovf_to_inf = !sign_q; end
            3'b100: begin inc = g;                  ovf_to_inf = 1'b1;    end
            default: ;
        endcase
    end

    always_comb begin
        if (rsig[MAN_W+1]) begin
            r_frac = rsig[MAN_W:1];
            r_exp  = exp_q + X_ONE;
        end else begin
            r_frac = rsig[MAN_W-1:0];
            r_exp  = rsig[MAN_W] ? exp_q : '0;
        end
    end

    always_comb begin
        rnd_num   = {sign_q, r_exp[EXP_W-1:0], r_frac};
        rnd_flags = {3'b000, tiny & inexact, inexact};
        if (m == '0) begin
            rnd_num   = {zsign, {(W-1){1'b0}}};
            rnd_flags = '0;
        end else if (ovf) begin
            rnd_num   = ovf_to_inf ? {sign_q, EXP_ONES, {MAN_W{1'b0}}}
                                   : {sign_q, EXP_MAXF, {MAN_W{1'b1}}};
            rnd_flags = 5'b00101;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        rm_d      = rm_q;
        sign_d    = sign_q;
        eff_sub_d = eff_sub_q;
        exp_d     = exp_q;
        mant_l_d  = mant_l_q;
        mant_s_d  = mant_s_q;
        sum_d     = sum_q;
        out_num_d = out_num_q;
        flags_d   = flags_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d  = num1;
                    b_d  = {sb2, num2[W-2:0]};
                    rm_d = rm;
                    if (special) begin
                        out_num_d = spec_num;
                        flags_d   = spec_flags;
                        state_d   = S_HOLD;
                    end else begin
                        state_d   = S_ALIGN;
                    end
                end
            end
            S_ALIGN: begin
                sign_d    = a_big ? a_q[W-1] : b_q[W-1];
                eff_sub_d = a_q[W-1] ^ b_q[W-1];
                exp_d     = xl;
                mant_l_d  = ml;
                mant_s_d  = ms_sh;
                state_d   = S_ADD;
            end
            S_ADD: begin
                sum_d   = eff_sub_q ? ({1'b0, mant_l_q} - {1'b0, mant_s_q})
                                    : ({1'b0, mant_l_q} + {1'b0, mant_s_q});
                state_d = S_NORM;
            end
            S_NORM: begin
                if (sum_q[DW]) begin
                    sum_d   = {1'b0, sum_q[DW:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + X_ONE;
                    state_d = S_ROUND;
                end else if ((sum_q == '0) || sum_q[DW-1] || (exp_q == X_ONE)) begin
                    state_d = S_ROUND;
                end else begin
                    // Shift and test the bit that becomes hidden, so each step costs one cycle.
                    sum_d = {sum_q[DW-1:0], 1'b0};
                    exp_d = exp_q - X_ONE;
                    if (sum_q[DW-2] || (exp_q == X_TWO)) state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                out_num_d = rnd_num;
                flags_d   = rnd_flags;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            rm_q      <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            exp_q     <= '0;
            mant_l_q  <= '0;
            mant_s_q  <= '0;
            sum_q     <= '0;
            out_num_q <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rm_q      <= rm_d;
            sign_q    <= sign_d;
            eff_sub_q <= eff_sub_d;
            exp_q     <= exp_d;
            mant_l_q  <= mant_l_d;
            mant_s_q  <= mant_s_d;
            sum_q     <= sum_d;
            out_num_q <= out_num_d;
            flags_q   <= flags_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_HOLD);
    assign out_num   = out_num_q;
    assign flags     = flags_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_fadd_pipe.sv
// Directed-vector bench for fadd_pipe (single precision): results, flags, latency,
// output hold under back-pressure and asynchronous reset in the middle of normalisation.
module tb_fadd_pipe;
    logic        clk, rst_n, in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] num1, num2, out_num;
    logic [2:0]  rm, dbg_state;
    logic [4:0]  flags;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [2:0]  rm;
        logic [31:0] exp_num;
        logic [4:0]  exp_flags;
        int          exp_lat;   // edges after the accept edge until out_valid
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    fadd_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .num1(num1), .num2(num2), .sub(sub), .rm(rm),
        .out_valid(out_valid), .out_ready(out_ready), .out_num(out_num),
        .flags(flags), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx, input int hold);
        int          lat;
        logic [31:0] first_num;
        @(negedge clk);
        check($sformatf("v%0d_in_ready_idle", idx), 32'(in_ready), 32'd1);
        num1 = v.a; num2 = v.b; sub = v.sub; rm = v.rm;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // Keep offering junk while busy; it must not be taken.
        num1 = $urandom; num2 = $urandom;
        sub = 1'($urandom_range(0, 1)); rm = 3'($urandom_range(0, 7));
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check($sformatf("v%0d_out_valid", idx), 32'(out_valid), 32'd1);
        check($sformatf("v%0d_num", idx), out_num, v.exp_num);
        check($sformatf("v%0d_flags", idx), 32'(flags), 32'(v.exp_flags));
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        first_num = out_num;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check($sformatf("v%0d_hold%0d_valid", idx, i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_hold%0d_num", idx, i), out_num, first_num);
            check($sformatf("v%0d_hold%0d_flags", idx, i), 32'(flags), 32'(v.exp_flags));
            check($sformatf("v%0d_hold%0d_in_ready", idx, i), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check($sformatf("v%0d_drain_valid", idx), 32'(out_valid), 32'd0);
        check($sformatf("v%0d_drain_ready", idx), 32'(in_ready), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 32'h40000000, 5'h00, 4};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 32'h00000000, 5'h00, 4};
        vecs[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 32'h80000000, 5'h00, 4};
        vecs[3]  = '{32'h3F800001, 32'h3F800000, 1'b1, 3'd0, 32'h34000000, 5'h00, 26};
        vecs[4]  = '{32'h3F800000, 32'h33800000, 1'b0, 3'd0, 32'h3F800000, 5'h01, 4};
        vecs[5]  = '{32'h3F800000, 32'h33800000, 1'b0, 3'd3, 32'h3F800001, 5'h01, 4};
        vecs[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 32'h7F800000, 5'h05, 4};
        vecs[7]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 32'h7F7FFFFF, 5'h05, 4};
        vecs[8]  = '{32'h7F800000, 32'h7F800000, 1'b1, 3'd0, 32'h7FC00000, 5'h10, 0};
        vecs[9]  = '{32'h00000001, 32'h00000001, 1'b0, 3'd0, 32'h00000002, 5'h00, 4};
        vecs[10] = '{32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 5'h10, 0};
        vecs[11] = '{32'h7FC00001, 32'h3F800000, 1'b0, 3'd0, 32'h7FC00000, 5'h00, 0};
        vecs[12] = '{32'hFF800000, 32'h3F800000, 1'b0, 3'd0, 32'hFF800000, 5'h00, 0};
        vecs[13] = '{32'h80000000, 32'h80000000, 1'b0, 3'd0, 32'h80000000, 5'h00, 4};
        vecs[14] = '{32'h00000000, 32'h00000000, 1'b1, 3'd0, 32'h00000000, 5'h00, 4};
        vecs[15] = '{32'h3F800000, 32'h3F000000, 1'b1, 3'd0, 32'h3F000000, 5'h00, 4};
        vecs[16] = '{32'h40000000, 32'hC0400000, 1'b0, 3'd0, 32'hBF800000, 5'h00, 4};
        vecs[17] = '{32'h00800000, 32'h00000001, 1'b1, 3'd0, 32'h007FFFFF, 5'h00, 4};
        vecs[18] = '{32'h3F800000, 32'h33800000, 1'b0, 3'd4, 32'h3F800001, 5'h01, 4};
        vecs[19] = '{32'hBF800000, 32'hB3800000, 1'b0, 3'd2, 32'hBF800001, 5'h01, 4};
        vecs[20] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 3'd0, 32'h40000000, 5'h01, 4};
        vecs[21] = '{32'h3F800000, 32'h33800000, 1'b0, 3'd5, 32'h3F800000, 5'h01, 4};
        vecs[22] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd2, 32'h7F7FFFFF, 5'h05, 4};
        vecs[23] = '{32'h3F800000, 32'h7F800000, 1'b1, 3'd0, 32'hFF800000, 5'h00, 0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        num1 = '0; num2 = '0; sub = 1'b0; rm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_num", out_num, 32'h0);
        check("reset_flags", 32'(flags), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i, 0);

        // Back-pressure: result must stay put for three cycles.
        run_vec(vecs[4], 100, 3);

        // Asynchronous reset while the long normalisation is in progress.
        @(negedge clk);
        num1 = 32'h3F800001; num2 = 32'h3F800000; sub = 1'b1; rm = 3'd0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("mid_norm_state", 32'(dbg_state), 32'd3);
        check("mid_norm_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        check("async_rst_state", 32'(dbg_state), 32'd0);
        check("async_rst_out_num", out_num, 32'h0);
        check("async_rst_flags", 32'(flags), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[5], 200, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
